shift_reg_tx: RTL and testbench

Parallel-to-serial transmitter for the floating-point adder's 16-bit serial link. Accepts a half-precision word on a parallel port and emits it one bit per cycle, LSB first, with a per-bit write strobe. This matches the deserializer's convention: bits arrive on the serial input, qualified by the write strobe, and are shifted in from the MSB. A one-word holding register gives gap-free back-to-back words, and a pause input stalls emission.

---
 rtl/shift_reg_tx_pkg.sv | 12 +
 rtl/shift_reg_tx.sv | 104 ++++++++++
 tb/tb_shift_reg_tx.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/shift_reg_tx_pkg.sv
// Shared definitions for the fp adder serial link (transmitter and deserializer).
package shift_reg_tx_pkg;

  localparam int unsigned FP_WORD_WIDTH = 16;
  localparam bit          LSB_FIRST     = 1'b1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } tx_state_e;

endpackage

// File: rtl/shift_reg_tx.sv
// Parallel-to-serial link transmitter: LSB first, per-bit write strobe,
// one-word holding register for gap-free back-to-back words, pause stalls emission.
module shift_reg_tx
  import shift_reg_tx_pkg::*;
#(
  parameter int unsigned WIDTH = FP_WORD_WIDTH
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             load_in,
  input  logic             pause_in,
  output logic             rdy_out,
  output logic             serial_out,
  output logic             wr_out,
  output logic             done_out
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] C_FULL  = CW'(WIDTH);
  localparam logic [CW-1:0] C_FIRST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] C_LAST  = CW'(1);

  tx_state_e        r_state;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_valid;
  logic [CW-1:0]    r_count;
  logic             r_serial;
  logic             r_wr;
  logic             r_done;
  logic             w_load_ok;

  assign rdy_out    = ~r_hold_valid;
  assign w_load_ok  = load_in & rdy_out;
  assign serial_out = r_serial;
  assign wr_out     = r_wr;
  assign done_out   = r_done;

  // r_count holds the number of bits still to be emitted from r_shift.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_count      <= '0;
      r_serial     <= 1'b0;
      r_wr         <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_wr   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_load_ok) begin
            r_state <= SHIFT;
            if (pause_in) begin
              r_shift <= parallel_in;
              r_count <= C_FULL;
            end else begin
              r_serial <= parallel_in[0];
              r_wr     <= 1'b1;
              r_shift  <= {1'b0, parallel_in[WIDTH-1:1]};
              r_count  <= C_FIRST;
            end
          end
        end
        SHIFT: begin
          if (pause_in) begin
            if (w_load_ok) begin
              r_hold       <= parallel_in;
              r_hold_valid <= 1'b1;
            end
          end else begin
            r_serial <= r_shift[0];
            r_wr     <= 1'b1;
            r_shift  <= {1'b0, r_shift[WIDTH-1:1]};
            r_count  <= r_count - C_LAST;
            if (r_count == C_LAST) begin
              r_done <= 1'b1;
              // Refill straight from the holding register, or let a fresh load bypass it.
              if (r_hold_valid) begin
                r_shift      <= r_hold;
                r_count      <= C_FULL;
                r_hold_valid <= 1'b0;
              end else if (w_load_ok) begin
                r_shift <= parallel_in;
                r_count <= C_FULL;
              end else begin
                r_state <= IDLE;
              end
            end else if (w_load_ok) begin
              r_hold       <= parallel_in;
              r_hold_valid <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_reg_tx.sv
// Directed bench for shift_reg_tx with a behavioural MSB-in deserializer for loopback.
module tb_shift_reg_tx;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [15:0] parallel_in;
  logic        load_in;
  logic        pause_in;
  logic        rdy_out;
  logic        serial_out;
  logic        wr_out;
  logic        done_out;

  logic [15:0] des_word;
  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  shift_reg_tx #(.WIDTH(16)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .parallel_in (parallel_in),
    .load_in     (load_in),
    .pause_in    (pause_in),
    .rdy_out     (rdy_out),
    .serial_out  (serial_out),
    .wr_out      (wr_out),
    .done_out    (done_out)
  );

  always #5 clk_in = ~clk_in;

  // Deserializer model: strobed bits shift in from the MSB.
  always @(posedge clk_in) begin
    if (rst_in) des_word <= '0;
    else if (wr_out) des_word <= {serial_out, des_word[15:1]};
  end

  task automatic step(input logic rst, input logic ld, input logic [15:0] d, input logic p);
    rst_in      = rst;
    load_in     = ld;
    parallel_in = d;
    pause_in    = p;
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Compare {wr, serial, done, rdy} in one go.
  task automatic check_out(input string tag, input logic ew, input logic es,
                           input logic ed, input logic er);
    check(tag, {12'h0, wr_out, serial_out, done_out, rdy_out}, {12'h0, ew, es, ed, er});
  endtask

  initial begin
    logic [15:0] w;
    logic [31:0] s;
    logic [19:0] pmask;
    logic        last_ser;
    int unsigned j;

    // Reset
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    check_out("reset", 1'b0, 1'b0, 1'b0, 1'b1);

    // Single word A5C3, unpaused
    w = 16'hA5C3;
    step(1'b0, 1'b1, w, 1'b0);
    check_out("a5c3_b0", 1'b1, w[0], 1'b0, 1'b1);
    for (int k = 1; k < 16; k++) begin
      step(1'b0, 1'b0, 16'h0, 1'b0);
      check_out($sformatf("a5c3_b%0d", k), 1'b1, w[k], k == 15, 1'b1);
    end
    step(1'b0, 1'b0, 16'h0, 1'b0);
    check_out("a5c3_idle", 1'b0, w[15], 1'b0, 1'b1);

    // Back-to-back 0001 then FFFF via holding register
    s = {16'hFFFF, 16'h0001};
    for (int k = 0; k < 32; k++) begin
      if (k == 0)      step(1'b0, 1'b1, 16'h0001, 1'b0);
      else if (k == 1) step(1'b0, 1'b1, 16'hFFFF, 1'b0);
      else             step(1'b0, 1'b0, 16'h0, 1'b0);
      check_out($sformatf("b2b_%0d", k), 1'b1, s[k], (k == 15) || (k == 31),
                !((k >= 1) && (k <= 14)));
    end
    step(1'b0, 1'b0, 16'h0, 1'b0);
    check_out("b2b_idle", 1'b0, 1'b1, 1'b0, 1'b1);

    // 8000 with two 2-cycle pauses (before bit 3 and bit 9)
    w = 16'h8000;
    pmask = 20'h01818;
    j = 0;
    last_ser = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step(1'b0, k == 0, w, pmask[k]);
      if (!pmask[k]) begin
        last_ser = w[j];
        j++;
      end
      check_out($sformatf("pause_%0d", k), !pmask[k], last_ser, k == 19, 1'b1);
    end
    step(1'b0, 1'b0, 16'h0, 1'b0);
    check_out("pause_idle", 1'b0, 1'b1, 1'b0, 1'b1);

    // Third load while holding is ignored
    s = {16'h5A5A, 16'h00FF};
    for (int k = 0; k < 32; k++) begin
      if (k == 0)      step(1'b0, 1'b1, 16'h00FF, 1'b0);
      else if (k == 1) step(1'b0, 1'b1, 16'h5A5A, 1'b0);
      else if (k == 2) step(1'b0, 1'b1, 16'h1234, 1'b0);
      else             step(1'b0, 1'b0, 16'h0, 1'b0);
      check_out($sformatf("drop_%0d", k), 1'b1, s[k], (k == 15) || (k == 31),
                !((k >= 1) && (k <= 14)));
    end
    step(1'b0, 1'b0, 16'h0, 1'b0);
    check_out("drop_idle", 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-word with a word held
    step(1'b0, 1'b1, 16'hFFFF, 1'b0);
    step(1'b0, 1'b1, 16'h0F0F, 1'b0);
    check_out("rst_held", 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 2; k < 8; k++) step(1'b0, 1'b0, 16'h0, 1'b0);
    check_out("rst_b7", 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    check_out("rst_mid", 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 1'b0, 16'h0, 1'b0);
      check_out($sformatf("rst_quiet_%0d", k), 1'b0, 1'b0, 1'b0, 1'b1);
    end

    // Loopback 3C00, loaded with pause high in IDLE
    w = 16'h3C00;
    step(1'b0, 1'b1, w, 1'b1);
    check_out("lb_load_paused", 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 16; k++) begin
      step(1'b0, 1'b0, 16'h0, 1'b0);
      check_out($sformatf("lb_b%0d", k), 1'b1, w[k], k == 15, 1'b1);
    end
    step(1'b0, 1'b0, 16'h0, 1'b0);
    check("lb_deser", des_word, 16'h3C00);
    check_out("lb_idle", 1'b0, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
